nibble_serial_add_ctrl: RTL
===========================

Name: nibble_serial_add_ctrl

Overview:
Sequencer that performs a wide addition by time-sharing a single 4-bit ripple-carry adder stage, one nibble per clock, LSB nibble first. It latches the operands on a start pulse, walks a nibble index, and chains the carry between cycles through a carry register. It presents a start/busy/done handshake and holds the wide result. It sits between the operand registers and downstream logic that needs sums wider than 4 bits.

Parameters:
NIBBLES, 4, number of 4-bit nibbles per operand (operand width = 4*NIBBLES); legal range 2..16

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
start  input  1  single-cycle request to begin an addition; sampled only when not busy
A  input  4*NIBBLES  operand A; latched on accepted start
B  input  4*NIBBLES  operand B; latched on accepted start
Ci  input  1  carry-in to nibble 0; latched on accepted start
sa  input  1  operand A enable; 0 forces A to zero for the whole operation; latched on start
sb  input  1  operand B enable; 0 forces B to zero for the whole operation; latched on start
busy  output  1  high while an addition is in progress
done  output  1  one-cycle pulse when S/Co become valid
S  output  4*NIBBLES  wide sum; valid from done until next accepted start
Co  output  1  carry-out of the top nibble; same validity as S

Behaviour:
- One clock domain: clk. Reset is synchronous and active-high on rst.
- Reset values: busy=0, done=0, S=0, Co=0, state=IDLE, nibble index=0, carry register=0.
- States: IDLE, RUN, DONE.
- IDLE: on start=1, latch A and B (each masked by sa/sb respectively), Ci, and set index=0, carry=Ci; go to RUN; busy=1 from the next cycle.
- RUN: each cycle, feed latched nibble[index] of A and B plus the carry register to the 4-bit stage; write the stage sum into S[4*index+3:4*index]; carry<=stage carry-out; index<=index+1. After processing index=NIBBLES-1, Co<=stage carry-out and go to DONE.
- DONE: done=1 for exactly one cycle, busy=0; return to IDLE. S/Co hold until the next accepted start.
- Latency: start sampled at edge 0 -> done high in cycle NIBBLES+1. Throughput is one addition per NIBBLES+2 cycles.
- S is not cleared on start. Nibbles above the current index hold their previous values until overwritten. Consumers use S only when done is high, or later.
- start while busy=1: ignored; no queuing; latched operands are unaffected.
- start in the DONE cycle: ignored (busy=0, but state is not IDLE). The earliest new start is accepted the cycle after done.
- A/B/Ci/sa/sb changing mid-operation: no effect.
- rst during RUN or DONE: abort immediately to reset values; no done pulse.
- Arithmetic: unsigned modulo 2^(4*NIBBLES). Co is the true carry-out of the MSB nibble. sa=sb=0 yields S=Ci, Co=0.
- Index width: clog2(NIBBLES) bits; no wrap past NIBBLES-1.

Decomposition:
- Shared package: state encoding constants (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the nibble width constant NIB_W=4.
- One sub-module: nibble_add_stage, a purely combinational 4-bit full-adder chain with operand-enable gating (inputs: a, b, ci, ena, enb; outputs: s, co). The controller instantiates it once. Operand masking is applied at latch time in the controller and also via ena/enb tied high at the stage.

Test Plan:
- NIBBLES=4; A=0x1234, B=0x1111, Ci=0, sa=sb=1, start pulse -> busy high cycles 1-4; done in cycle 5; S=0x2345, Co=0.
- A=0xFFFF, B=0x0001, Ci=0 -> carry ripples across all nibbles; S=0x0000, Co=1, done at cycle 5.
- A=0xABCD, B=0x0F0F, Ci=1, sa=0, sb=1 -> S=0x0F10, Co=0. Then sa=sb=0, Ci=1 -> S=0x0001, Co=0.
- Start accepted with A=0x0001, B=0x0001. Assert start again with A=0xFFFF at cycle 2 and at the DONE cycle -> both ignored; result S=0x0002, exactly one done pulse.
- Start with A=0x8888, B=0x8888. Assert rst in cycle 3 -> next cycle busy=0, done=0, S=0, Co=0; no done pulse. A new start after reset completes normally: S=0x1110, Co=1.
- Back-to-back: issue start the cycle after done -> second operation is accepted; done recurs exactly NIBBLES+2 cycles after the first done.

Source files
------------

// File: rtl/nibble_serial_add_ctrl_pkg.sv
// Shared constants for the nibble-serial adder: FSM encoding and nibble width.
package nibble_serial_add_ctrl_pkg;

  localparam int NIB_W = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef logic [NIB_W-1:0] nibble_t;

endpackage

// File: rtl/nibble_serial_add_ctrl_stage.sv
// Combinational 4-bit ripple-carry stage with per-operand enable gating.
module nibble_add_stage
  import nibble_serial_add_ctrl_pkg::*;
(
  input  nibble_t a,
  input  nibble_t b,
  input  logic    ci,
  input  logic    ena,
  input  logic    enb,
  output nibble_t s,
  output logic    co
);

  nibble_t          am;
  nibble_t          bm;
  logic [NIB_W:0]   c;

  assign am   = a & {NIB_W{ena}};
  assign bm   = b & {NIB_W{enb}};
  assign c[0] = ci;

  generate
    for (genvar gi = 0; gi < NIB_W; gi++) begin : g_fa
      assign s[gi]   = am[gi] ^ bm[gi] ^ c[gi];
      assign c[gi+1] = (am[gi] & bm[gi]) | (c[gi] & (am[gi] ^ bm[gi]));
    end
  endgenerate

  assign co = c[NIB_W];

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// Wide adder that reuses one 4-bit stage, one nibble per clock, LSB first,
// with a start/busy/done handshake and a held result.
module nibble_serial_add_ctrl
  import nibble_serial_add_ctrl_pkg::*;
#(
  parameter int NIBBLES = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [NIB_W*NIBBLES-1:0] A,
  input  logic [NIB_W*NIBBLES-1:0] B,
  input  logic                     Ci,
  input  logic                     sa,
  input  logic                     sb,
  output logic                     busy,
  output logic                     done,
  output logic [NIB_W*NIBBLES-1:0] S,
  output logic                     Co
);

  localparam int W     = NIB_W * NIBBLES;
  localparam int IDX_W = $clog2(NIBBLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  logic [1:0]       state_reg;
  logic [IDX_W-1:0] idx_reg;
  logic             carry_reg;
  logic [W-1:0]     a_reg;
  logic [W-1:0]     b_reg;
  logic [W-1:0]     s_reg;
  logic             co_reg;

  nibble_t          stage_s;
  logic             stage_co;

  // Bit offset of the current nibble; idx*4 expressed as a shift.
  logic [IDX_W+1:0] bit_ofs;
  assign bit_ofs = {idx_reg, 2'b00};

  nibble_add_stage u_stage (
    .a   (a_reg[bit_ofs +: NIB_W]),
    .b   (b_reg[bit_ofs +: NIB_W]),
    .ci  (carry_reg),
    .ena (1'b1),
    .enb (1'b1),
    .s   (stage_s),
    .co  (stage_co)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      idx_reg   <= '0;
      carry_reg <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      s_reg     <= '0;
      co_reg    <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            a_reg     <= sa ? A : '0;
            b_reg     <= sb ? B : '0;
            carry_reg <= Ci;
            idx_reg   <= '0;
            state_reg <= ST_RUN;
          end
        end
        ST_RUN: begin
          // Upper nibbles of S keep stale data until this walk reaches them.
          s_reg[bit_ofs +: NIB_W] <= stage_s;
          carry_reg               <= stage_co;
          if (idx_reg == LAST_IDX) begin
            co_reg    <= stage_co;
            state_reg <= ST_DONE;
          end else begin
            idx_reg <= idx_reg + 1'b1;
          end
        end
        ST_DONE: state_reg <= ST_IDLE;
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state_reg == ST_RUN);
  assign done = (state_reg == ST_DONE);
  assign S    = s_reg;
  assign Co   = co_reg;

endmodule
